// File: rtl/dp_ctrl_pkg.sv
// Shared encodings for the X/Y/Z register + ULA datapath control.
// Imported by the sequencer and by any later datapath blocks.
package dp_ctrl_pkg;

    typedef enum logic [1:0] {
        REG_HOLD   = 2'b00,
        REG_LOAD   = 2'b01,
        REG_SHIFTR = 2'b10,
        REG_RESET  = 2'b11
    } reg_ctrl_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SHR = 2'b10,
        OP_CLR = 2'b11
    } opcode_e;

    localparam int unsigned ULA_OP_ADD = 0;
    localparam int unsigned ULA_OP_SUB = 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD_X  = 3'd1,
        S_LOAD_Y  = 3'd2,
        S_SHIFT   = 3'd3,
        S_WRITE_Z = 3'd4,
        S_CLEAR   = 3'd5,
        S_DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/shift_down_counter.sv
// Loadable down-counter that tracks the remaining shift steps.
// Load takes priority over decrement; reset over both.
module shift_down_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             is_one_o,
    output logic             is_zero_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign is_one_o  = (cnt_q == WIDTH'(1));
    assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/datapath_sequencer.sv
// Sequencer for the X/Y/Z register + ULA datapath: one op per start/busy
// handshake, driving registered register-control codes and the ULA op.
module datapath_sequencer
    import dp_ctrl_pkg::*;
#(
    parameter int unsigned SHAMT_W = 3,
    parameter int unsigned ULA_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         opcode,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [1:0]         Tx,
    output logic [1:0]         Ty,
    output logic [1:0]         Tz,
    output logic [ULA_W-1:0]   Tula
);

    state_e  state_q, state_d;
    opcode_e op_q, op_d;
    logic    accept;
    logic    cnt_dec;
    logic    cnt_one;
    logic    cnt_zero;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       tx_q, tx_d;
    logic [1:0]       ty_q, ty_d;
    logic [1:0]       tz_q, tz_d;
    logic [ULA_W-1:0] tula_q, tula_d;

    shift_down_counter #(
        .WIDTH(SHAMT_W)
    ) u_shift_cnt (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (accept),
        .load_val_i (shamt),
        .dec_i      (cnt_dec),
        .is_one_o   (cnt_one),
        .is_zero_o  (cnt_zero)
    );

    // State register; outputs are registered from the next-state decode so
    // they line up with the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= REG_HOLD;
            ty_q    <= REG_HOLD;
            tz_q    <= REG_HOLD;
            tula_q  <= ULA_W'(ULA_OP_ADD);
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            tz_q    <= tz_d;
            tula_q  <= tula_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        accept  = 1'b0;
        cnt_dec = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept = 1'b1;
                    op_d   = opcode_e'(opcode);
                    if (op_d == OP_SHR) begin
                        state_d = S_LOAD_Y;
                    end else if (op_d == OP_CLR) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_LOAD_X;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_X: state_d = S_LOAD_Y;
            S_LOAD_Y: begin
                if (op_q == OP_SHR && !cnt_zero) begin
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_WRITE_Z;
                end
            end
            // Exit while the counter still reads 1 so exactly shamt SHIFT cycles occur.
            S_SHIFT: begin
                cnt_dec = 1'b1;
                if (cnt_one) begin
                    state_d = S_WRITE_Z;
                end
            end
            S_WRITE_Z: state_d = S_DONE;
            S_CLEAR:   state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        tx_d   = REG_HOLD;
        ty_d   = REG_HOLD;
        tz_d   = REG_HOLD;
        tula_d = ULA_W'(ULA_OP_ADD);
        case (state_d)
            S_LOAD_X: begin
                busy_d = 1'b1;
                tx_d   = REG_LOAD;
                ty_d   = REG_RESET;
                tz_d   = REG_RESET;
            end
            S_LOAD_Y: begin
                busy_d = 1'b1;
                tx_d   = (op_d == OP_SHR) ? REG_RESET : REG_HOLD;
                ty_d   = REG_LOAD;
            end
            S_SHIFT: begin
                busy_d = 1'b1;
                ty_d   = REG_SHIFTR;
            end
            S_WRITE_Z: begin
                busy_d = 1'b1;
                tx_d   = REG_RESET;
                ty_d   = REG_RESET;
                tz_d   = REG_LOAD;
            end
            S_CLEAR: begin
                busy_d = 1'b1;
                tx_d   = REG_RESET;
                ty_d   = REG_RESET;
                tz_d   = REG_RESET;
            end
            S_DONE: done_d = 1'b1;
            default: ;
        endcase
        if (state_d inside {S_LOAD_X, S_LOAD_Y, S_SHIFT, S_WRITE_Z} && op_d == OP_SUB) begin
            tula_d = ULA_W'(ULA_OP_SUB);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Tx   = tx_q;
    assign Ty   = ty_q;
    assign Tz   = tz_q;
    assign Tula = tula_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Scoreboard bench for datapath_sequencer: each issued op pushes its expected
// per-cycle output trace; a negedge monitor pops and compares.
module tb_datapath_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] opcode;
    logic [2:0] shamt;
    logic       busy;
    logic       done;
    logic [1:0] Tx;
    logic [1:0] Ty;
    logic [1:0] Tz;
    logic [1:0] Tula;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic        mon_en = 1'b0;

    // Packed vector: {busy, done, Tx, Ty, Tz, Tula}
    logic [9:0] exp_q[$];

    datapath_sequencer #(
        .SHAMT_W(3),
        .ULA_W  (2)
    ) dut (
        .clock  (clk),
        .reset  (reset),
        .start  (start),
        .opcode (opcode),
        .shamt  (shamt),
        .busy   (busy),
        .done   (done),
        .Tx     (Tx),
        .Ty     (Ty),
        .Tz     (Tz),
        .Tula   (Tula)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void pushv(input logic b, input logic d, input logic [1:0] x,
                                  input logic [1:0] y, input logic [1:0] z, input logic [1:0] u);
        exp_q.push_back({b, d, x, y, z, u});
    endfunction

    // Expected cycle-by-cycle behaviour of one operation, from the op tables.
    function automatic void push_trace(input logic [1:0] op, input logic [2:0] n);
        logic [1:0] u;
        u = (op == 2'b01) ? 2'd1 : 2'd0;
        case (op)
            2'b00, 2'b01: begin
                pushv(1, 0, 2'b01, 2'b11, 2'b11, u);
                pushv(1, 0, 2'b00, 2'b01, 2'b00, u);
                pushv(1, 0, 2'b11, 2'b11, 2'b01, u);
            end
            2'b10: begin
                pushv(1, 0, 2'b11, 2'b01, 2'b00, 2'd0);
                for (int i = 0; i < int'(n); i++) pushv(1, 0, 2'b00, 2'b10, 2'b00, 2'd0);
                pushv(1, 0, 2'b11, 2'b11, 2'b01, 2'd0);
            end
            default: pushv(1, 0, 2'b11, 2'b11, 2'b11, 2'd0);
        endcase
        pushv(0, 1, 2'b00, 2'b00, 2'b00, 2'd0);
    endfunction

    always @(negedge clk) begin
        logic [9:0] act;
        logic [9:0] e;
        if (mon_en) begin
            act = {busy, done, Tx, Ty, Tz, Tula};
            total++;
            if (busy === 1'b1 || done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_activity: got %b want idle 0000000000", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        bad++;
                        $display("FAIL op_cycle t=%0t: got %b want %b", $time, act, e);
                    end
                end
            end else if (act !== 10'b0) begin
                bad++;
                $display("FAIL idle_outputs t=%0t: got %b want 0000000000", $time, act);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] n);
        start  = 1'b1;
        opcode = op;
        shamt  = n;
        push_trace(op, n);
        step();
        start  = 1'b0;
        opcode = 2'($urandom);
        shamt  = 3'($urandom);
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else step();
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: got no done within 64 cycles want done pulse");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang want completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        opcode = 2'b00;
        shamt  = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Directed: ADD, SUB, SHR 5/0/7, CLR then back-to-back ADD.
        issue(2'b00, 3'd0); wait_done(); step();
        issue(2'b01, 3'd0); wait_done(); step();
        issue(2'b10, 3'd5); wait_done(); step();
        issue(2'b10, 3'd0); wait_done(); step();
        issue(2'b10, 3'd7); wait_done(); step();
        issue(2'b11, 3'd0); wait_done();
        issue(2'b00, 3'd0); wait_done(); step();

        // start pulsed during SHIFT is ignored.
        issue(2'b10, 3'd4);
        step();
        start = 1'b1; opcode = 2'b11; shamt = 3'd1;
        step();
        start = 1'b0;
        wait_done(); step(); step();

        // Reset in the 3rd SHIFT cycle of shamt=6, then a normal ADD.
        issue(2'b10, 3'd6);
        step(); step(); step();
        reset = 1'b1;
        start = 1'b1; opcode = 2'b01;
        step();
        reset = 1'b0;
        start = 1'b0;
        exp_q.delete();
        step();
        issue(2'b00, 3'd0); wait_done(); step();

        // Randomized ops, busy-time start pulses, back-to-back and gaps.
        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) begin
                start  = 1'b1;
                opcode = 2'($urandom);
                shamt  = 3'($urandom);
                step();
                start  = 1'b0;
            end
            wait_done();
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) step();
            end
        end

        repeat (3) step();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
